// File: rtl/buzzer_scheduler.sv
// ============================================================================
// Module   : buzzer_scheduler
// Function : Fixed-priority arbiter that lends one buzzer to four requesters
//            and plays N ON/OFF beeps followed by a mandatory silent gap.
//            Optional macro BUZZER_SCHED_PREEMPT_EN lets a lower-index
//            requester take the buzzer from the current owner.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module buzzer_scheduler #(
  parameter int TICK_DIV  = 1024,
  parameter int ON_TICKS  = 4,
  parameter int OFF_TICKS = 4,
  parameter int GAP_TICKS = 16
) (
  input  logic        iClock,
  input  logic        iReset_n,
  input  logic [3:0]  iReq,
  input  logic [15:0] iBeeps,
  output logic [3:0]  oGrant,
  output logic [3:0]  oDone,
  output logic        oBusy,
  output logic        oBuzz
);

  localparam int C_ON_LEN  = ON_TICKS  * TICK_DIV;
  localparam int C_OFF_LEN = OFF_TICKS * TICK_DIV;
  localparam int C_GAP_LEN = GAP_TICKS * TICK_DIV;
  localparam int C_MAX_LEN = (C_ON_LEN > C_OFF_LEN) ?
                             ((C_ON_LEN > C_GAP_LEN) ? C_ON_LEN : C_GAP_LEN) :
                             ((C_OFF_LEN > C_GAP_LEN) ? C_OFF_LEN : C_GAP_LEN);
  localparam int C_CNT_W   = (C_MAX_LEN > 1) ? $clog2(C_MAX_LEN + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]         r_state;
  logic [C_CNT_W-1:0] r_cnt;
  logic [3:0]         r_remain;
  logic [3:0]         r_grant;
  logic               r_abort;
  logic [3:0]         r_done;
  logic               r_buzz;
  logic               r_busy;

  logic [1:0]         w_state_nxt;
  logic [C_CNT_W-1:0] w_cnt_nxt;
  logic [3:0]         w_remain_nxt;
  logic [3:0]         w_grant_nxt;
  logic               w_abort_nxt;
  logic               w_finish;
  logic [3:0]         w_done_nxt;
  logic               w_buzz_nxt;
  logic               w_busy_nxt;

  logic [3:0]         w_pick;
  logic [3:0]         w_pick_beeps;
  logic [C_CNT_W-1:0] w_limit;
  logic               w_expire;
  logic               w_owner_req;
  logic               w_preempt;

  // Lowest set bit of the request vector wins.
  assign w_pick      = iReq & (~iReq + 4'd1);
  assign w_owner_req = |(iReq & r_grant);
  assign w_expire    = (r_cnt == w_limit);

`ifdef BUZZER_SCHED_PREEMPT_EN
  assign w_preempt = |(iReq & (r_grant - 4'd1));
`else
  assign w_preempt = 1'b0;
`endif

  always_comb begin
    w_pick_beeps = 4'd0;
    for (int k = 0; k < 4; k++) begin
      if (w_pick[k]) w_pick_beeps = iBeeps[4*k +: 4];
    end
  end

  always_comb begin
    case (r_state)
      S_ON:    w_limit = C_CNT_W'(C_ON_LEN - 1);
      S_OFF:   w_limit = C_CNT_W'(C_OFF_LEN - 1);
      S_GAP:   w_limit = C_CNT_W'(C_GAP_LEN - 1);
      default: w_limit = '0;
    endcase
  end

  // State register
  always_ff @(posedge iClock) begin
    if (!iReset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_remain <= 4'd0;
      r_grant  <= 4'd0;
      r_abort  <= 1'b0;
      r_done   <= 4'd0;
      r_buzz   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_remain <= w_remain_nxt;
      r_grant  <= w_grant_nxt;
      r_abort  <= w_abort_nxt;
      r_done   <= w_done_nxt;
      r_buzz   <= w_buzz_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + 1'b1;
    w_remain_nxt = r_remain;
    w_grant_nxt  = r_grant;
    w_abort_nxt  = r_abort;
    w_finish     = 1'b0;
    if ((r_state != S_IDLE) && w_preempt) begin
      w_state_nxt  = S_ON;
      w_cnt_nxt    = '0;
      w_grant_nxt  = w_pick;
      w_remain_nxt = w_pick_beeps;
      w_abort_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          if (|iReq) begin
            w_state_nxt  = S_ON;
            w_grant_nxt  = w_pick;
            w_remain_nxt = w_pick_beeps;
            w_abort_nxt  = 1'b0;
          end
        end
        S_ON, S_OFF: begin
          if (!w_owner_req) begin
            w_state_nxt  = S_GAP;
            w_cnt_nxt    = '0;
            w_remain_nxt = 4'd0;
            w_abort_nxt  = 1'b1;
          end else if ((r_state == S_ON) && (r_remain == 4'd0)) begin
            // Zero-beep grant: release right away without any sound or gap.
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_grant_nxt = 4'd0;
            w_finish    = 1'b1;
          end else if (w_expire) begin
            w_cnt_nxt = '0;
            if (r_state == S_ON) begin
              w_remain_nxt = r_remain - 4'd1;
              w_state_nxt  = (r_remain == 4'd1) ? S_GAP : S_OFF;
            end else begin
              w_state_nxt = S_ON;
            end
          end
        end
        default: begin
          if (w_expire) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_grant_nxt = 4'd0;
            w_abort_nxt = 1'b0;
            w_finish    = !r_abort;
          end
        end
      endcase
    end
  end

  // Output logic, registered through the state register process
  always_comb begin
    w_done_nxt = w_finish ? r_grant : 4'd0;
    w_buzz_nxt = (w_state_nxt == S_ON) && (w_remain_nxt != 4'd0);
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign oGrant = r_grant;
  assign oDone  = r_done;
  assign oBusy  = r_busy;
  assign oBuzz  = r_buzz;

endmodule

`default_nettype wire

// File: tb/tb_buzzer_scheduler.sv
// ============================================================================
// Module   : tb_buzzer_scheduler
// Function : Directed self-checking bench for buzzer_scheduler
//            (TICK_DIV=2, ON_TICKS=2, OFF_TICKS=1, GAP_TICKS=3).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_buzzer_scheduler;

  localparam int C_ON_CYC  = 4;
  localparam int C_OFF_CYC = 2;
  localparam int C_GAP_CYC = 6;

  logic        iClock = 1'b0;
  logic        iReset_n = 1'b0;
  logic [3:0]  iReq = 4'd0;
  logic [15:0] iBeeps = 16'd0;
  logic [3:0]  oGrant;
  logic [3:0]  oDone;
  logic        oBusy;
  logic        oBuzz;

  int n_checks = 0;
  int n_fail   = 0;

  buzzer_scheduler #(
    .TICK_DIV (2),
    .ON_TICKS (2),
    .OFF_TICKS(1),
    .GAP_TICKS(3)
  ) u_dut (
    .iClock  (iClock),
    .iReset_n(iReset_n),
    .iReq    (iReq),
    .iBeeps  (iBeeps),
    .oGrant  (oGrant),
    .oDone   (oDone),
    .oBusy   (oBusy),
    .oBuzz   (oBuzz)
  );

  always #5 iClock = ~iClock;

  task automatic cyc();
    @(posedge iClock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] d,
                         input logic bz, input logic by);
    chk({tag, ".grant"}, oGrant, g);
    chk({tag, ".done"},  oDone,  d);
    chk({tag, ".buzz"},  4'(oBuzz), 4'(bz));
    chk({tag, ".busy"},  4'(oBusy), 4'(by));
  endtask

  // Entered on the grant cycle; ends on the cycle carrying the done pulse.
  task automatic run_owner(input string tag, input logic [3:0] g, input int n);
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < C_ON_CYC; c++) begin
        chk_all({tag, ".on"}, g, 4'd0, 1'b1, 1'b1);
        cyc();
      end
      if (b < n - 1) begin
        for (int c = 0; c < C_OFF_CYC; c++) begin
          chk_all({tag, ".off"}, g, 4'd0, 1'b0, 1'b1);
          cyc();
        end
      end
    end
    for (int c = 0; c < C_GAP_CYC; c++) begin
      chk_all({tag, ".gap"}, g, 4'd0, 1'b0, 1'b1);
      cyc();
    end
    chk_all({tag, ".done"}, 4'd0, g, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    cyc();
    cyc();
    chk_all("reset", 4'd0, 4'd0, 1'b0, 1'b0);
    iReset_n = 1'b1;
    cyc();
    chk_all("idle", 4'd0, 4'd0, 1'b0, 1'b0);

    // Single request, three beeps; iBeeps change after grant is ignored
    iReq   = 4'b0010;
    iBeeps = 16'h0030;
    cyc();
    iBeeps = 16'h00F0;
    run_owner("single", 4'b0010, 3);
    iReq = 4'd0;
    cyc();
    chk_all("single.post", 4'd0, 4'd0, 1'b0, 1'b0);

    // Simultaneous requests: 1 before 3, separated by the done/IDLE cycle
    iReq   = 4'b1010;
    iBeeps = 16'h1010;
    cyc();
    run_owner("simul1", 4'b0010, 1);
    iReq = 4'b1000;
    cyc();
    run_owner("simul3", 4'b1000, 1);
    iReq = 4'd0;
    cyc();
    chk_all("simul.post", 4'd0, 4'd0, 1'b0, 1'b0);

    // Zero beep count
    iReq   = 4'b0001;
    iBeeps = 16'h0000;
    cyc();
    chk_all("zero.grant", 4'b0001, 4'd0, 1'b0, 1'b1);
    cyc();
    chk_all("zero.done", 4'd0, 4'b0001, 1'b0, 1'b0);
    iReq = 4'd0;
    cyc();
    chk_all("zero.post", 4'd0, 4'd0, 1'b0, 1'b0);

    // Abort in the second ON cycle
    iReq   = 4'b0100;
    iBeeps = 16'h0200;
    cyc();
    chk_all("abort.on0", 4'b0100, 4'd0, 1'b1, 1'b1);
    cyc();
    chk_all("abort.on1", 4'b0100, 4'd0, 1'b1, 1'b1);
    iReq = 4'd0;
    cyc();
    for (int c = 0; c < C_GAP_CYC; c++) begin
      chk_all("abort.gap", 4'b0100, 4'd0, 1'b0, 1'b1);
      cyc();
    end
    chk_all("abort.end", 4'd0, 4'd0, 1'b0, 1'b0);
    cyc();
    chk_all("abort.post", 4'd0, 4'd0, 1'b0, 1'b0);

    // Reset in the middle of ON
    iReq   = 4'b0001;
    iBeeps = 16'h0003;
    cyc();
    chk_all("rst.on0", 4'b0001, 4'd0, 1'b1, 1'b1);
    cyc();
    iReset_n = 1'b0;
    cyc();
    chk_all("rst.clear", 4'd0, 4'd0, 1'b0, 1'b0);
    iReset_n = 1'b1;
    cyc();
    chk_all("rst.regrant", 4'b0001, 4'd0, 1'b1, 1'b1);
    iReset_n = 1'b0;
    iReq     = 4'd0;
    cyc();
    chk_all("rst.clear2", 4'd0, 4'd0, 1'b0, 1'b0);
    iReset_n = 1'b1;
    cyc();

    // Owner 3 in OFF when requester 0 arrives
    iReq   = 4'b1000;
    iBeeps = 16'h2000;
    cyc();
    for (int c = 0; c < C_ON_CYC; c++) begin
      chk_all("pre.on", 4'b1000, 4'd0, 1'b1, 1'b1);
      cyc();
    end
    chk_all("pre.off0", 4'b1000, 4'd0, 1'b0, 1'b1);
    iReq   = 4'b1001;
    iBeeps = 16'h2001;
    cyc();
`ifdef BUZZER_SCHED_PREEMPT_EN
    chk_all("pre.take", 4'b0001, 4'd0, 1'b1, 1'b1);
    iReq = 4'b0001;
    cyc();
    run_owner("pre.new", 4'b0001, 1);
    iReq = 4'd0;
    cyc();
    chk_all("pre.post", 4'd0, 4'd0, 1'b0, 1'b0);
`else
    chk_all("nopre.off1", 4'b1000, 4'd0, 1'b0, 1'b1);
    cyc();
    run_owner("nopre.own3", 4'b1000, 1);
    iReq = 4'b0001;
    cyc();
    chk_all("nopre.next", 4'b0001, 4'd0, 1'b1, 1'b1);
    iReq = 4'd0;
    cyc();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
